// File: rtl/lcd_bus_scheduler_if.sv
// Requester and LCD pin bundle for the 8080-style write bus scheduler.
// master drives the requests; slave is the scheduler side.
interface lcd_bus_scheduler_if #(
  parameter int DATA_W = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_dc;
  logic [DATA_W-1:0] cmd_data;
  logic              pix_valid;
  logic              pix_ready;
  logic [DATA_W-1:0] pix_data;
  logic              pix_last;
  logic              lcd_csx;
  logic              lcd_dcx;
  logic              lcd_wrx;
  logic [DATA_W-1:0] lcd_data;
  logic              busy;
  logic              grant_pix;

  modport master (
    output cmd_valid, cmd_dc, cmd_data,
    output pix_valid, pix_data, pix_last,
    input  cmd_ready, pix_ready,
    input  lcd_csx, lcd_dcx, lcd_wrx, lcd_data,
    input  busy, grant_pix
  );

  modport slave (
    input  cmd_valid, cmd_dc, cmd_data,
    input  pix_valid, pix_data, pix_last,
    output cmd_ready, pix_ready,
    output lcd_csx, lcd_dcx, lcd_wrx, lcd_data,
    output busy, grant_pix
  );
endinterface

// File: rtl/lcd_bus_scheduler.sv
// Round-robin CPU/DMA arbiter and WRX strobe sequencer for the LCD bus.
// Pixel bursts hold the bus until the word flagged pix_last is written.
module lcd_bus_scheduler #(
  parameter int DATA_W         = 16,
  parameter int WR_LOW_CYCLES  = 2,
  parameter int WR_HIGH_CYCLES = 2
) (
  input logic clk,
  input logic reset_n,
  lcd_bus_scheduler_if.slave bus
);

  localparam int MAXC = (WR_LOW_CYCLES > WR_HIGH_CYCLES) ?
                        WR_LOW_CYCLES : WR_HIGH_CYCLES;
  localparam int CNT_W = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_WR_LOW,
    S_WR_HIGH,
    S_BURST_WAIT
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              dcx_q, dcx_d;
  logic              plast_q, plast_d;
  logic              lock_q, lock_d;
  logic              lsrc_q, lsrc_d;

  logic gnt_cmd, gnt_pix;
  logic phase_done, burst_more;
  logic cmd_rdy, pix_rdy;
  logic cmd_xfer, pix_xfer;
  logic csx, wrx;

  // lsrc_q=1 means the pixel source was served last
  assign gnt_cmd    = bus.cmd_valid && (!bus.pix_valid || lsrc_q);
  assign gnt_pix    = bus.pix_valid && !gnt_cmd;
  assign phase_done = (cnt_q == '0);
  assign burst_more = lock_q && !plast_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      dcx_q   <= 1'b1;
      plast_q <= 1'b0;
      lock_q  <= 1'b0;
      lsrc_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      dcx_q   <= dcx_d;
      plast_q <= plast_d;
      lock_q  <= lock_d;
      lsrc_q  <= lsrc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    dcx_d   = dcx_q;
    plast_d = plast_q;
    lock_d  = lock_q;
    lsrc_d  = lsrc_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_xfer || pix_xfer) state_d = S_SETUP;
      end
      S_SETUP: state_d = S_WR_LOW;
      S_WR_LOW: begin
        if (phase_done) state_d = S_WR_HIGH;
      end
      S_WR_HIGH: begin
        if (phase_done) begin
          if (!burst_more) begin
            state_d = S_IDLE;
            lock_d  = 1'b0;
          end else if (bus.pix_valid) begin
            state_d = S_SETUP;
          end else begin
            state_d = S_BURST_WAIT;
          end
        end
      end
      S_BURST_WAIT: begin
        if (bus.pix_valid) state_d = S_SETUP;
      end
      default: state_d = S_IDLE;
    endcase

    if (pix_xfer) begin
      data_d  = bus.pix_data;
      dcx_d   = 1'b1;
      plast_d = bus.pix_last;
      lock_d  = 1'b1;
      lsrc_d  = 1'b1;
    end else if (cmd_xfer) begin
      data_d  = bus.cmd_data;
      dcx_d   = bus.cmd_dc;
      plast_d = 1'b0;
      lsrc_d  = 1'b0;
    end
  end

  // one down-counter shared by both strobe phases, reloaded on entry
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      unique case (state_d)
        S_WR_LOW:  cnt_d = CNT_W'(WR_LOW_CYCLES - 1);
        S_WR_HIGH: cnt_d = CNT_W'(WR_HIGH_CYCLES - 1);
        default:   cnt_d = '0;
      endcase
    end else if (!phase_done) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_comb begin
    csx     = (state_q == S_IDLE);
    wrx     = (state_q != S_WR_LOW);
    cmd_rdy = (state_q == S_IDLE) && gnt_cmd;
    pix_rdy = ((state_q == S_IDLE) && gnt_pix) ||
              ((state_q == S_WR_HIGH) && phase_done && burst_more) ||
              (state_q == S_BURST_WAIT);
  end

  assign cmd_xfer = bus.cmd_valid && cmd_rdy;
  assign pix_xfer = bus.pix_valid && pix_rdy;

  assign bus.cmd_ready = cmd_rdy;
  assign bus.pix_ready = pix_rdy;
  assign bus.lcd_csx   = csx;
  assign bus.lcd_wrx   = wrx;
  assign bus.lcd_dcx   = dcx_q;
  assign bus.lcd_data  = data_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.grant_pix = lock_q;

endmodule
